buffer_rx: RTL and testbench
============================

# buffer_rx

Receive FIFO between the UART receiver and the calculator controller. It drains every byte from the UART's `dato_rx`/`rx_valido`/`rx_leido` handshake as soon as the byte appears, so that keystrokes arriving while the controller is busy are not lost. Examples of busy periods are an arithmetic operation, BCD conversion, or result transmission. It re-presents the buffered bytes to the controller with the same valid/acknowledge-pulse protocol. After each pop it inserts a mandatory one-cycle valid-low gap, because the controller re-arms its read flag only when valid is seen low.

## Interface
- `PROFUNDIDAD`, 16: number of entries; must be a power of two, ≥ 2.
- `ANCHO`, 8: byte width.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `dato_uart`  in  ANCHO: byte from the UART receiver; stable while `uart_valido` = 1.
- `uart_valido`  in  1: UART has a byte; a level held until acknowledged.
- `uart_leido`  out  1: one-cycle acknowledge pulse to the UART.
- `dato_rx`  out  ANCHO: byte at the head of the FIFO.
- `rx_valido`  out  1: head byte is available to the controller.
- `rx_leido`  in  1: one-cycle pop pulse from the controller.
- `limpiar`  in  1: synchronous flush.
- `nivel`  out  $clog2(PROFUNDIDAD)+1: occupancy, 0..PROFUNDIDAD.
- `desbordado`  out  1: sticky overflow flag.

## Operation
- Reset (async, `rst` = 1):
  - pointers, `nivel`, `uart_leido`, `rx_valido`, `dato_rx` and `desbordado` all go to 0;
  - capture FSM goes to `CAPTURA`; presentation FSM goes to `VACIO`.
- Capture FSM:
  - `CAPTURA`: if `uart_valido` = 1, register a push and set `uart_leido` = 1 for the next cycle, then go to `ESPERA_BAJA`.
  - `ESPERA_BAJA`: return to `CAPTURA` only when `uart_valido` = 0. A byte is never captured twice.
- Push:
  - accepted if `nivel` < PROFUNDIDAD, or if a pop occurs in the same cycle;
  - otherwise the byte is acknowledged anyway, discarded, and `desbordado` is set to 1.
- Presentation FSM:
  - `VACIO`: `rx_valido` = 0. Move to `PRESENTA` when `nivel` > 0.
  - `PRESENTA`: `rx_valido` = 1 and `dato_rx` = head byte. On `rx_leido`, pop, then go to `HUECO`.
  - `HUECO`: `rx_valido` = 0 for exactly one cycle. Then go to `PRESENTA` if `nivel` > 0, else `VACIO`.
- `rx_leido` outside `PRESENTA` is ignored; it causes no pop and no pointer change.
- Simultaneous push and pop: both take effect and `nivel` is unchanged. If `nivel` = PROFUNDIDAD, the push is accepted because a slot is freed.
- Pointers are `$clog2(PROFUNDIDAD)` bits and wrap modulo PROFUNDIDAD. `nivel` is a separate counter and never wraps.
- `limpiar` = 1:
  - next edge: pointers and `nivel` go to 0, `desbordado` goes to 0, presentation FSM goes to `VACIO`;
  - it has priority over a same-cycle push or pop;
  - the capture FSM keeps its handshake state, so a byte being acknowledged in that cycle is dropped.
- `desbordado` is cleared only by `rst` or `limpiar`.

## Timing
- All outputs are registered.
- `uart_valido` rises before edge N: the write occurs at edge N, `uart_leido` = 1 during cycle N+1, and `nivel` is incremented after edge N.
- Empty FIFO: `rx_valido` rises after edge N+1, giving push-to-valid latency of 2 cycles.
- Pop pulse sampled at edge M: `rx_valido` = 0 during cycle M+1. The next byte, if any, is valid after edge M+1. Minimum spacing between presented bytes is 2 cycles.
- `dato_rx` is updated in the same edge that raises `rx_valido` and is held stable while `rx_valido` = 1.
- Back-to-back UART bytes: 1 capture per ≥ 2 cycles. This is far above the UART byte rate.

## Structure
- Shared package `calc_pkg`:
  - `ANCHO_BYTE` = 8;
  - enum types for the capture FSM (`CAPTURA`, `ESPERA_BAJA`) and the presentation FSM (`VACIO`, `PRESENTA`, `HUECO`).
- One sub-module, `ram_fifo`:
  - PROFUNDIDAD×ANCHO storage;
  - synchronous write, asynchronous read;
  - the top registers `dato_rx` from it.
- The top holds both FSMs, the pointers, `nivel` and `desbordado`.

## Test plan
- Reset mid-operation: assert `rst` with `nivel` = 5 and `rx_valido` = 1 -> all outputs 0 immediately. After release, `nivel` = 0 and `rx_valido` = 0.
- Single byte: push 0x35 ("5") -> `uart_leido` pulses 1 cycle, `rx_valido` = 1 with `dato_rx` = 0x35 two cycles later. Pop -> `rx_valido` low and `nivel` = 0.
- Order and gap: push "1","2","+","3" with no pops, then pop continuously -> bytes appear in order 0x31, 0x32, 0x2B, 0x33, with `rx_valido` low exactly 1 cycle between each.
- Overflow and full-cycle simultaneity:
  - Push 17 bytes 0x41..0x51 with PROFUNDIDAD = 16 -> `nivel` = 16, `desbordado` = 1, byte 0x51 discarded and still acknowledged.
  - Drain -> 0x41..0x50.
  - With `nivel` = 16, push and pop in the same cycle -> push accepted, `nivel` stays 16.
- Wrap-around: run 40 push/pop pairs -> data intact across the pointer wrap. `rx_leido` asserted while `rx_valido` = 0 -> `nivel` unchanged.
- Flush: `limpiar` with `nivel` = 7 and `desbordado` = 1 -> next cycle `nivel` = 0, `desbordado` = 0, `rx_valido` = 0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator datapath.
// Also holds the state encodings for both buffer_rx FSMs.
package calc_pkg;

    localparam int unsigned ANCHO_BYTE = 8;

    typedef enum logic {
        CAPTURA,
        ESPERA_BAJA
    } est_cap_t;

    typedef enum logic [1:0] {
        VACIO,
        PRESENTA,
        HUECO
    } est_pres_t;

endpackage

// File: rtl/ram_fifo.sv
// Storage array for the receive FIFO.
// Writes are synchronous and reads are asynchronous, so the top can register the head byte.
module ram_fifo #(
    parameter int unsigned PROFUNDIDAD = 16,
    parameter int unsigned ANCHO       = 8
) (
    input  logic                           clk,
    input  logic                           wr_en,
    input  logic [$clog2(PROFUNDIDAD)-1:0] wr_addr,
    input  logic [ANCHO-1:0]               wr_data,
    input  logic [$clog2(PROFUNDIDAD)-1:0] rd_addr,
    output logic [ANCHO-1:0]               rd_data
);

    logic [ANCHO-1:0] mem [PROFUNDIDAD];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/buffer_rx.sv
// Receive FIFO between the UART receiver and the calculator controller.
// It drains UART bytes at once and re-presents them with a one-cycle valid-low gap after each pop.
module buffer_rx
    import calc_pkg::*;
#(
    parameter int unsigned PROFUNDIDAD = 16,
    parameter int unsigned ANCHO       = ANCHO_BYTE
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ANCHO-1:0]                 dato_uart,
    input  logic                             uart_valido,
    output logic                             uart_leido,
    output logic [ANCHO-1:0]                 dato_rx,
    output logic                             rx_valido,
    input  logic                             rx_leido,
    input  logic                             limpiar,
    output logic [$clog2(PROFUNDIDAD):0]     nivel,
    output logic                             desbordado
);

    localparam int unsigned PW = $clog2(PROFUNDIDAD);
    localparam int unsigned NW = PW + 1;

    est_cap_t  est_cap, est_cap_sig;
    est_pres_t est_pres, est_pres_sig;

    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [ANCHO-1:0] ram_dato;

    logic push_c, pop_c, lleno_c, acepta_c, desborda_c;

    ram_fifo #(
        .PROFUNDIDAD (PROFUNDIDAD),
        .ANCHO       (ANCHO)
    ) u_ram (
        .clk     (clk),
        .wr_en   (acepta_c),
        .wr_addr (wr_ptr),
        .wr_data (dato_uart),
        .rd_addr (rd_ptr),
        .rd_data (ram_dato)
    );

    // State registers for both FSMs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            est_cap  <= CAPTURA;
            est_pres <= VACIO;
        end else begin
            est_cap  <= est_cap_sig;
            est_pres <= est_pres_sig;
        end
    end

    // Next-state logic; a flush forces the presentation side idle
    always_comb begin
        est_cap_sig  = est_cap;
        est_pres_sig = est_pres;

        case (est_cap)
            CAPTURA:     if (uart_valido)  est_cap_sig = ESPERA_BAJA;
            ESPERA_BAJA: if (!uart_valido) est_cap_sig = CAPTURA;
            default:     est_cap_sig = CAPTURA;
        endcase

        case (est_pres)
            VACIO:    if (nivel != '0) est_pres_sig = PRESENTA;
            PRESENTA: if (rx_leido)    est_pres_sig = HUECO;
            HUECO:    est_pres_sig = (nivel != '0) ? PRESENTA : VACIO;
            default:  est_pres_sig = VACIO;
        endcase

        if (limpiar) begin
            est_pres_sig = VACIO;
        end
    end

    // Per-cycle push/pop decisions
    always_comb begin
        push_c     = 1'b0;
        pop_c      = 1'b0;
        lleno_c    = 1'b0;
        acepta_c   = 1'b0;
        desborda_c = 1'b0;

        push_c     = (est_cap == CAPTURA) && uart_valido;
        pop_c      = (est_pres == PRESENTA) && rx_leido && !limpiar;
        lleno_c    = (nivel == NW'(PROFUNDIDAD));
        acepta_c   = push_c && (!lleno_c || pop_c) && !limpiar;
        desborda_c = push_c && lleno_c && !pop_c;
    end

    // Pointers, occupancy and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            nivel      <= '0;
            uart_leido <= 1'b0;
            rx_valido  <= 1'b0;
            dato_rx    <= '0;
            desbordado <= 1'b0;
        end else begin
            uart_leido <= push_c;
            rx_valido  <= (est_pres_sig == PRESENTA);

            // Head byte is latched only on entry to PRESENTA and held while valid
            if ((est_pres_sig == PRESENTA) && (est_pres != PRESENTA)) begin
                dato_rx <= ram_dato;
            end

            if (limpiar) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                nivel      <= '0;
                desbordado <= 1'b0;
            end else begin
                if (acepta_c) wr_ptr <= wr_ptr + PW'(1);
                if (pop_c)    rd_ptr <= rd_ptr + PW'(1);

                case ({acepta_c, pop_c})
                    2'b10:   nivel <= nivel + NW'(1);
                    2'b01:   nivel <= nivel - NW'(1);
                    default: nivel <= nivel;
                endcase

                if (desborda_c) desbordado <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_buffer_rx.sv
// Directed self-checking bench for buffer_rx.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_buffer_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dato_uart;
    logic       uart_valido;
    logic       uart_leido;
    logic [7:0] dato_rx;
    logic       rx_valido;
    logic       rx_leido;
    logic       limpiar;
    logic [4:0] nivel;
    logic       desbordado;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    buffer_rx #(
        .PROFUNDIDAD (16),
        .ANCHO       (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dato_uart   (dato_uart),
        .uart_valido (uart_valido),
        .uart_leido  (uart_leido),
        .dato_rx     (dato_rx),
        .rx_valido   (rx_valido),
        .rx_leido    (rx_leido),
        .limpiar     (limpiar),
        .nivel       (nivel),
        .desbordado  (desbordado)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One UART handshake: raise valid, expect the acknowledge one cycle later, drop valid
    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        dato_uart   = b;
        uart_valido = 1'b1;
        @(negedge clk);
        check("uart_leido_ack", 32'(uart_leido), 32'd1);
        uart_valido = 1'b0;
    endtask

    // Wait (bounded) for a presented byte, check it, pop it, check the gap cycle
    task automatic pop_expect(input logic [7:0] exp, output int waited);
        waited = 0;
        while (rx_valido !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("rx_valido_wait", 32'(rx_valido), 32'd1);
        check("dato_rx", 32'(dato_rx), 32'(exp));
        rx_leido = 1'b1;
        @(negedge clk);
        rx_leido = 1'b0;
        check("gap_after_pop", 32'(rx_valido), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        logic [7:0] orden [4];
        logic [7:0] v;

        orden[0] = 8'h31; orden[1] = 8'h32; orden[2] = 8'h2B; orden[3] = 8'h33;

        rst = 1'b1; dato_uart = '0; uart_valido = 1'b0; rx_leido = 1'b0; limpiar = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_nivel", 32'(nivel), 32'd0);
        check("reset_rx_valido", 32'(rx_valido), 32'd0);
        check("reset_uart_leido", 32'(uart_leido), 32'd0);
        check("reset_desbordado", 32'(desbordado), 32'd0);
        check("reset_dato_rx", 32'(dato_rx), 32'd0);
        rst = 1'b0;

        // Single byte: 2-cycle push-to-valid latency
        push_byte(8'h35);
        check("single_nivel", 32'(nivel), 32'd1);
        check("single_not_yet_valid", 32'(rx_valido), 32'd0);
        @(negedge clk);
        check("single_valid", 32'(rx_valido), 32'd1);
        check("single_dato", 32'(dato_rx), 32'h35);
        check("single_ack_one_cycle", 32'(uart_leido), 32'd0);
        pop_expect(8'h35, w);
        check("single_wait", 32'(w), 32'd0);
        check("single_nivel_after", 32'(nivel), 32'd0);

        // Order and one-cycle gap under continuous popping
        for (int i = 0; i < 4; i++) push_byte(orden[i]);
        check("order_nivel", 32'(nivel), 32'd4);
        for (int i = 0; i < 4; i++) begin
            pop_expect(orden[i], w);
            if (i > 0) check("order_gap_len", 32'(w), 32'd1);
        end
        check("order_nivel_after", 32'(nivel), 32'd0);

        // Overflow: 17 bytes into 16 slots, last one acknowledged and dropped
        for (int i = 0; i < 17; i++) push_byte(8'(8'h41 + i));
        check("ovf_nivel", 32'(nivel), 32'd16);
        check("ovf_flag", 32'(desbordado), 32'd1);
        @(negedge clk);
        check("ovf_head", 32'(dato_rx), 32'h41);
        dato_uart   = 8'h52;
        uart_valido = 1'b1;
        rx_leido    = 1'b1;
        @(negedge clk);
        uart_valido = 1'b0;
        rx_leido    = 1'b0;
        check("full_simul_nivel", 32'(nivel), 32'd16);
        check("full_simul_ack", 32'(uart_leido), 32'd1);
        check("full_simul_gap", 32'(rx_valido), 32'd0);
        for (int i = 1; i < 16; i++) pop_expect(8'(8'h41 + i), w);
        pop_expect(8'h52, w);
        check("drain_nivel", 32'(nivel), 32'd0);
        check("drain_flag_sticky", 32'(desbordado), 32'd1);

        // Wrap-around with push/pop pairs
        for (int i = 0; i < 40; i++) begin
            v = 8'(i * 7 + 3);
            push_byte(v);
            pop_expect(v, w);
        end
        check("wrap_nivel", 32'(nivel), 32'd0);

        // Pop pulse while not presenting is ignored
        push_byte(8'hA5);
        check("ign_not_valid", 32'(rx_valido), 32'd0);
        rx_leido = 1'b1;
        @(negedge clk);
        rx_leido = 1'b0;
        check("ign_nivel", 32'(nivel), 32'd1);
        check("ign_valid", 32'(rx_valido), 32'd1);
        check("ign_dato", 32'(dato_rx), 32'hA5);
        pop_expect(8'hA5, w);

        // Flush with 7 entries and the overflow flag still set
        for (int i = 0; i < 7; i++) push_byte(8'(8'h60 + i));
        check("flush_pre_nivel", 32'(nivel), 32'd7);
        check("flush_pre_flag", 32'(desbordado), 32'd1);
        limpiar = 1'b1;
        @(negedge clk);
        limpiar = 1'b0;
        check("flush_nivel", 32'(nivel), 32'd0);
        check("flush_flag", 32'(desbordado), 32'd0);
        check("flush_valid", 32'(rx_valido), 32'd0);
        @(negedge clk);
        check("flush_valid_stays", 32'(rx_valido), 32'd0);

        // Reset mid-operation
        for (int i = 0; i < 5; i++) push_byte(8'(8'h70 + i));
        @(negedge clk);
        check("midrst_pre_nivel", 32'(nivel), 32'd5);
        check("midrst_pre_valid", 32'(rx_valido), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_nivel", 32'(nivel), 32'd0);
        check("midrst_valid", 32'(rx_valido), 32'd0);
        check("midrst_dato", 32'(dato_rx), 32'd0);
        check("midrst_leido", 32'(uart_leido), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("postrst_nivel", 32'(nivel), 32'd0);
        check("postrst_valid", 32'(rx_valido), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
